// File: rtl/adc_channel_sequencer.sv
// adc_channel_sequencer
//
// Purpose:
//   Round-robin conversion scheduler for a 4-input serial ADC. Time is cut
//   into frames of FRAME_LEN sclk cycles. At each frame boundary the next
//   enabled channel is chosen and presented on adc_addr for the following
//   frame. The ADC converts that address one frame later, and the result is
//   tagged with its channel and stored as the latest value for that channel.
//
// Ports:
//   clk          in   1     ADC sclk, all state updates on the rising edge
//   rst_n        in   1     synchronous reset, active low
//   chan_en      in   4     channel enable mask (bit i = channel i)
//   adc_addr     out  2     channel address driven to the ADC this frame
//   adc_data     in   DW    conversion result from the ADC interface
//   frame_start  out  1     high during the first cycle of every frame
//   sample       out  DW    most recently delivered result
//   sample_chan  out  2     channel that produced sample
//   sample_valid out  1     one-cycle pulse when sample/sample_chan update
//   chan_data    out  4*DW  latest result per channel, ch i at [i*DW +: DW]

module adc_channel_sequencer #(
  parameter int FRAME_LEN = 16,
  parameter int DW        = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      chan_en,
  output logic [1:0]      adc_addr,
  input  logic [DW-1:0]   adc_data,
  output logic            frame_start,
  output logic [DW-1:0]   sample,
  output logic [1:0]      sample_chan,
  output logic            sample_valid,
  output logic [4*DW-1:0] chan_data
);

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  logic [CW-1:0] fcnt;
  logic          cur_vld;
  logic [1:0]    pend_chan;
  logic          pend_vld;
  logic          first;

  logic [1:0]    search_start;
  logic [1:0]    next_chan;
  logic [1:0]    idx;
  logic          found;

  assign frame_start = (fcnt == '0);

  // Round-robin pick: scan the mask upward from search_start with wrap.
  // Iterating from the farthest offset down lets the nearest enabled
  // channel overwrite any farther candidate.
  always_comb begin
    search_start = first ? 2'd0 : adc_addr + 2'd1;
    next_chan    = adc_addr;
    found        = 1'b0;
    idx          = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = search_start + 2'(k);
      if (chan_en[idx]) begin
        next_chan = idx;
        found     = 1'b1;
      end
    end
  end

  // Frame counter and the two-stage conversion pipeline. cur_* tracks the
  // address being driven now; pend_* tracks the address being converted now,
  // whose result arrives on adc_data at the last cycle of this frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fcnt         <= '0;
      adc_addr     <= 2'd0;
      cur_vld      <= 1'b0;
      pend_chan    <= 2'd0;
      pend_vld     <= 1'b0;
      first        <= 1'b1;
      sample       <= '0;
      sample_chan  <= 2'd0;
      sample_valid <= 1'b0;
      chan_data    <= '0;
    end else begin
      sample_valid <= 1'b0;
      fcnt         <= (fcnt == LAST) ? '0 : fcnt + CW'(1);
      if (fcnt == LAST) begin
        if (pend_vld) begin
          sample                        <= adc_data;
          sample_chan                   <= pend_chan;
          chan_data[pend_chan*DW +: DW] <= adc_data;
          sample_valid                  <= 1'b1;
        end
        pend_chan <= adc_addr;
        pend_vld  <= cur_vld;
        // With an empty mask the address is left where it was so the ADC
        // keeps seeing a stable value; the slot is simply marked invalid.
        if (found) begin
          adc_addr <= next_chan;
          cur_vld  <= 1'b1;
          first    <= 1'b0;
        end else begin
          cur_vld  <= 1'b0;
        end
      end
    end
  end

endmodule
